matrix_vector_engine: RTL

- Parametrised successor to the fixed 4x4 matrix-vector datapath; this block owns both its controller and its datapath.
- Loads one DIM x DIM matrix once, then streams work items. Each work item is one DIM-element input vector.
- For each work item it computes the DIM-element product and writes it back over simple valid/ready memory ports.
- Sits between the AXI-facing register block (which supplies addresses and the start command) and the memory arbiter.

---
 rtl/matrix_vector_engine_pkg.sv | 13 +
 rtl/matrix_vector_engine_mac_unit.sv | 23 ++
 rtl/matrix_vector_engine.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/matrix_vector_engine_pkg.sv
// Shared state encoding and sizing helpers for the matrix-vector engine.
package matrix_engine_pkg;

    typedef enum logic [2:0] {IDLE, LD_MAT, LD_VEC, MAC, WRITE, FINISH} state_t;

    localparam int BYTES_PER_WORD = 4;

    // Index width for a cache of n entries; never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_vector_engine_mac_unit.sv
// Registered multiply-accumulate; 'first' restarts the sum with the current product.
module mac_unit
    import matrix_engine_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             first,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (en)
            acc <= (first ? '0 : acc) + a * b;
    end

endmodule

// File: rtl/matrix_vector_engine.sv
// Matrix-vector engine: loads a DIM x DIM matrix once, then multiplies a stream of vectors by it.
module matrix_vector_engine
    import matrix_engine_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DIM        = 4,
    parameter int WI_BITS    = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WI_BITS-1:0]    work_item_count,
    input  logic [ADDR_WIDTH-1:0] matrix_addr,
    input  logic [ADDR_WIDTH-1:0] data_in_addr,
    input  logic [ADDR_WIDTH-1:0] data_out_addr,
    output logic                  rd_req_valid,
    input  logic                  rd_req_ready,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_resp_valid,
    input  logic [WIDTH-1:0]      rd_resp_data,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0]      wr_data,
    output logic                  busy,
    output logic                  done
);

    localparam int MI = idx_bits(DIM * DIM);
    localparam int VI = idx_bits(DIM);
    localparam int OW = WI_BITS + 4;

    state_t                state;
    logic [ADDR_WIDTH-1:0] mat_base, in_base, out_base;
    logic [WI_BITS-1:0]    count, k;
    logic [MI-1:0]         idx;
    logic [VI-1:0]         r, j;
    logic                  rd_pend;
    logic                  resp_take;
    logic [WIDTH-1:0]      mat [DIM*DIM];
    logic [WIDTH-1:0]      vec [DIM];
    logic [MI-1:0]         m_sel;
    logic [OW-1:0]         in_off, out_off;
    logic [WIDTH-1:0]      acc;

    assign resp_take = rd_pend && rd_resp_valid;
    assign m_sel     = MI'(r) * MI'(DIM) + MI'(j);
    assign in_off    = OW'(k) * OW'(DIM) + OW'(idx);
    assign out_off   = OW'(k) * OW'(DIM) + OW'(r);
    assign wr_data   = acc;

    mac_unit #(.WIDTH(WIDTH)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == MAC),
        .first (j == '0),
        .a     (mat[m_sel]),
        .b     (vec[j]),
        .acc   (acc)
    );

    // Caches are pure storage; a response only lands while a read is outstanding.
    always_ff @(posedge clk) begin
        if (resp_take) begin
            if (state == LD_MAT)
                mat[idx] <= rd_resp_data;
            else
                vec[idx[VI-1:0]] <= rd_resp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mat_base     <= '0;
            in_base      <= '0;
            out_base     <= '0;
            count        <= '0;
            k            <= '0;
            idx          <= '0;
            r            <= '0;
            j            <= '0;
            rd_pend      <= 1'b0;
            rd_req_valid <= 1'b0;
            rd_addr      <= '0;
            wr_valid     <= 1'b0;
            wr_addr      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mat_base <= matrix_addr;
                    in_base  <= data_in_addr;
                    out_base <= data_out_addr;
                    count    <= work_item_count;
                    k        <= '0;
                    idx      <= '0;
                    r        <= '0;
                    j        <= '0;
                    busy     <= 1'b1;
                    if (work_item_count == '0) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        state <= LD_MAT;
                    end
                end
                LD_MAT, LD_VEC: begin
                    if (!rd_req_valid && !rd_pend) begin
                        rd_req_valid <= 1'b1;
                        rd_addr      <= (state == LD_MAT)
                            ? mat_base + ADDR_WIDTH'(idx) * ADDR_WIDTH'(BYTES_PER_WORD)
                            : in_base + ADDR_WIDTH'(in_off) * ADDR_WIDTH'(BYTES_PER_WORD);
                    end else if (rd_req_valid && rd_req_ready) begin
                        rd_req_valid <= 1'b0;
                        rd_pend      <= 1'b1;
                    end else if (resp_take) begin
                        rd_pend <= 1'b0;
                        if (state == LD_MAT && idx == MI'(DIM*DIM - 1)) begin
                            idx   <= '0;
                            state <= LD_VEC;
                        end else if (state == LD_VEC && idx == MI'(DIM - 1)) begin
                            idx   <= '0;
                            r     <= '0;
                            j     <= '0;
                            state <= MAC;
                        end else begin
                            idx <= idx + MI'(1);
                        end
                    end
                end
                MAC: begin
                    if (j == VI'(DIM - 1)) begin
                        j        <= '0;
                        wr_valid <= 1'b1;
                        wr_addr  <= out_base + ADDR_WIDTH'(out_off) * ADDR_WIDTH'(BYTES_PER_WORD);
                        state    <= WRITE;
                    end else begin
                        j <= j + VI'(1);
                    end
                end
                WRITE: if (wr_ready) begin
                    wr_valid <= 1'b0;
                    if (r != VI'(DIM - 1)) begin
                        r     <= r + VI'(1);
                        state <= MAC;
                    end else if (k != count - WI_BITS'(1)) begin
                        k     <= k + WI_BITS'(1);
                        r     <= '0;
                        idx   <= '0;
                        state <= LD_VEC;
                    end else begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
